// File: rtl/led_pio_pkg.sv
// Shared constants for the LED output port: register map and STATUS layout.
package led_pio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TOGGLE = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd6;

  // Bit position of the blink phase inside the STATUS register.
  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/led_pio_blink_timer.sv
// Blink engine: free-running prescaler producing a one-clock tick, a
// half-period counter clocked by that tick, and the blink phase flag.
module blink_timer #(
  parameter int PRESCALE   = 50000,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] period,
  input  logic                  period_wr,
  output logic                  phase
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]         pre_q, pre_d;
  logic                  tick;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  assign tick  = (pre_q == PRE_MAX);
  assign phase = phase_q;

  // Prescaler wraps at PRESCALE-1 and is never cleared by bus activity.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Blink count/phase: a PERIOD write restarts the half-period and wins
  // over a coincident tick; PERIOD=0 parks everything at zero.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (period == '0) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (cnt_q == period - DATA_WIDTH'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + DATA_WIDTH'(1);
      end
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/led_pio.sv
// Avalon-MM LED output port: DATA register with atomic set/clear/toggle
// aliases, per-bit blink mask, blink period and a registered read path.
// Bus handshake: a write is accepted on any rising clk with chipselect=1 and
// write_n=0 (no wait states); reads need no strobe and readdata always
// returns the register addressed on the previous edge.
module led_pio
  import led_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    PRESCALE    = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  wr;
  logic                  period_wr;
  logic                  phase;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;

  assign wr        = chipselect & ~write_n;
  assign period_wr = wr && (address == ADDR_PERIOD);

  // Write decode: the alias addresses modify DATA in place.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d   = writedata;
        ADDR_SET:    data_d   = data_q | writedata;
        ADDR_CLEAR:  data_d   = data_q & ~writedata;
        ADDR_TOGGLE: data_d   = data_q ^ writedata;
        ADDR_MASK:   mask_d   = writedata;
        ADDR_PERIOD: period_d = writedata;
        default:     ;
      endcase
    end
  end

  // Read mux built from the pre-write register values.
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:   rd_d = data_q;
      ADDR_MASK:   rd_d = mask_q;
      ADDR_PERIOD: rd_d = period_q;
      ADDR_STATUS: rd_d[STATUS_PHASE_BIT] = phase;
      default:     rd_d = '0;
    endcase
  end

  // Register file and read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      rd_q     <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      rd_q     <= rd_d;
    end
  end

  blink_timer #(
    .PRESCALE   (PRESCALE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_blink (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (period_q),
    .period_wr (period_wr),
    .phase     (phase)
  );

  assign readdata = rd_q;
  // Masked bits go dark while the phase is 1.
  assign out_port = data_q & ~(mask_q & {DATA_WIDTH{phase}});

endmodule

// File: tb/tb_led_pio.sv
// Bench for led_pio with DATA_WIDTH=10, PRESCALE=4, RESET_VALUE=0x155.
module tb_led_pio;

  localparam int          W   = 10;
  localparam int          PS  = 4;
  localparam logic [W-1:0] RV = 10'h155;

  logic         clk;
  logic         reset_n;
  logic         chipselect;
  logic [2:0]   address;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] readdata;
  logic [W-1:0] out_port;

  int n_pass;
  int n_total;

  // Reference model state: registers plus edges since reset and ticks since
  // the last PERIOD write; the phase is derived arithmetically from these.
  logic [W-1:0] m_data, m_mask, m_period;
  int           m_edge;
  int           m_ticks;

  led_pio #(
    .DATA_WIDTH  (W),
    .RESET_VALUE (RV),
    .PRESCALE    (PS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic m_phase();
    if (m_period == '0) return 1'b0;
    return ((m_ticks / int'(m_period)) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] m_out();
    return m_data & ~(m_mask & {W{m_phase()}});
  endfunction

  function automatic logic [W-1:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd4:    return m_mask;
      3'd5:    return m_period;
      3'd6:    return {{(W-1){1'b0}}, m_phase()};
      default: return '0;
    endcase
  endfunction

  task automatic m_reset();
    m_data   = RV;
    m_mask   = '0;
    m_period = '0;
    m_edge   = 0;
    m_ticks  = 0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One bus cycle: drive, clock, advance the model, compare after the edge.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [W-1:0] wd);
    logic [W-1:0] exp_rd;
    logic         tick;
    logic         wr;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    exp_rd = m_read(a);
    tick   = (m_edge % PS) == PS - 1;
    wr     = cs && !wn;
    if (wr) begin
      case (a)
        3'd0: m_data = wd;
        3'd1: m_data = m_data | wd;
        3'd2: m_data = m_data & ~wd;
        3'd3: m_data = m_data ^ wd;
        3'd4: m_mask = wd;
        3'd5: begin m_period = wd; m_ticks = 0; end
        default: ;
      endcase
    end
    if (!(wr && a == 3'd5) && tick) m_ticks++;
    m_edge++;
    #1;
    check($sformatf("readdata@a%0d", a), readdata, exp_rd);
    check("out_port", out_port, m_out());
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [W-1:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    step(1'b0, 1'b1, a, '0);
  endtask

  initial begin
    logic [2:0]   ra;
    logic [W-1:0] rw;
    bit           seen;
    n_pass = 0;
    n_total = 0;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = '0;
    writedata = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("reset_out_port", out_port, RV);
    check("reset_readdata", readdata, '0);
    reset_n = 1'b1;

    // Reset values readable at every address.
    for (int i = 0; i < 8; i++) rd_reg(3'(i));
    check("reset_out_final", out_port, 10'h155);

    // Direct write then set/clear/toggle on consecutive cycles.
    wr_reg(3'd0, 10'h0F0); check("seq_data", out_port, 10'h0F0);
    wr_reg(3'd1, 10'h003); check("seq_set", out_port, 10'h0F3);
    wr_reg(3'd2, 10'h030); check("seq_clear", out_port, 10'h0C3);
    wr_reg(3'd3, 10'h201); check("seq_toggle", out_port, 10'h2C2);
    rd_reg(3'd0);
    rd_reg(3'd0); check("seq_readback", readdata, 10'h2C2);

    // Blink the low nibble with PERIOD=2.
    wr_reg(3'd0, 10'h3FF);
    wr_reg(3'd4, 10'h00F);
    wr_reg(3'd5, 10'd2);
    for (int i = 0; i < 40; i++) rd_reg((i % 2) ? 3'd6 : 3'd5);

    // Wait for phase 1 via STATUS, then disable blinking.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      rd_reg(3'd6);
      if (readdata[0] === 1'b1 && out_port === 10'h3F0) seen = 1'b1;
    end
    check("wait_phase1", {9'd0, seen}, 10'd1);
    wr_reg(3'd5, 10'd0);
    check("period0_out", out_port, 10'h3FF);
    for (int i = 0; i < 20; i++) begin
      rd_reg(3'd6);
      check("period0_hold", out_port, 10'h3FF);
    end

    // PERIOD write coinciding with a terminal (toggling) tick.
    wr_reg(3'd5, 10'd2);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((m_edge % PS) == PS - 1 && ((m_ticks + 1) % int'(m_period)) == 0) seen = 1'b1;
      else rd_reg(3'd6);
    end
    check("found_terminal", {9'd0, seen}, 10'd1);
    wr_reg(3'd5, 10'd3);
    rd_reg(3'd6);
    check("term_phase0", readdata, 10'd0);
    for (int i = 0; i < 30; i++) rd_reg(3'd6);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      ra = 3'($urandom_range(0, 7));
      rw = W'($urandom);
      if (ra == 3'd5) rw = W'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
    end

    // Asynchronous reset mid-blink.
    wr_reg(3'd0, 10'h3FF);
    wr_reg(3'd4, 10'h3C3);
    wr_reg(3'd5, 10'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      rd_reg(3'd0);
      if (out_port === 10'h03C) seen = 1'b1;
    end
    check("pre_reset_blink", {9'd0, seen}, 10'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_port", out_port, RV);
    check("async_readdata", readdata, '0);
    @(negedge clk);
    check("reset_held_out", out_port, RV);
    reset_n = 1'b1;
    m_reset();
    for (int i = 0; i < 20; i++) begin
      rd_reg(3'(i % 8));
      check("post_reset_quiet", out_port, RV);
    end
    wr_reg(3'd4, 10'h00F);
    wr_reg(3'd5, 10'd1);
    for (int i = 0; i < 20; i++) rd_reg(3'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
